// File: rtl/sonar_burst_tx.sv
// Differential 40 kHz transducer burst generator with break-before-make dead time
// and a ring-down holdoff that blanks the receive path after each burst.
module sonar_burst_tx #(
  parameter int unsigned HALF_PERIOD = 337,
  parameter int unsigned DEAD        = 8,
  parameter int unsigned HOLDOFF     = 2700
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       start,
  input  logic       abort,
  input  logic [5:0] burstLen,
  output logic       pulseP,
  output logic       pulseN,
  output logic       busy,
  output logic       blank,
  output logic       done
);

  localparam int unsigned MAX_CNT = (HALF_PERIOD > HOLDOFF) ? HALF_PERIOD : HOLDOFF;
  localparam int unsigned CNT_W   = ($clog2(MAX_CNT + 1) > 12) ? $clog2(MAX_CNT + 1) : 12;

  localparam logic [CNT_W-1:0] DRV_LAST  = CNT_W'(HALF_PERIOD - DEAD - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD > 0) ? DEAD - 1 : 0);
  localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    IDLE,
    DRV_P,
    DEAD_P,
    DRV_N,
    DEAD_N,
    RING
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] phase_cnt;
  logic [5:0]       period_cnt;
  logic [5:0]       len_q;
  logic             drive_state;
  logic             last_period;

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    drive_state = (state == DRV_P) || (state == DEAD_P) ||
                  (state == DRV_N) || (state == DEAD_N);
    // Widened compare so a 63-period burst cannot wrap the period counter.
    last_period = (({1'b0, period_cnt} + 7'd1) >= {1'b0, len_q});
  end

  // NOTE: all state and output registers use non-blocking assignments so every
  // update in this block sees the values from before the clock edge.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      phase_cnt  <= '0;
      period_cnt <= '0;
      len_q      <= '0;
      pulseP     <= 1'b0;
      pulseN     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && drive_state) begin
        state     <= RING;
        phase_cnt <= '0;
        pulseP    <= 1'b0;
        pulseN    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              len_q      <= burstLen;
              phase_cnt  <= '0;
              period_cnt <= '0;
              busy       <= 1'b1;
              if (burstLen != 6'd0) begin
                state  <= DRV_P;
                pulseP <= 1'b1;
              end else begin
                state <= RING;
              end
            end
          end

          DRV_P: begin
            if (phase_cnt == DRV_LAST) begin
              phase_cnt <= '0;
              pulseP    <= 1'b0;
              if (DEAD != 0) begin
                state <= DEAD_P;
              end else begin
                state  <= DRV_N;
                pulseN <= 1'b1;
              end
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end

          DEAD_P: begin
            if (phase_cnt == DEAD_LAST) begin
              phase_cnt <= '0;
              state     <= DRV_N;
              pulseN    <= 1'b1;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end

          DRV_N: begin
            if (phase_cnt == DRV_LAST) begin
              phase_cnt <= '0;
              pulseN    <= 1'b0;
              if (DEAD != 0) begin
                state <= DEAD_N;
              end else begin
                period_cnt <= period_cnt + 6'd1;
                if (last_period) begin
                  state <= RING;
                end else begin
                  state  <= DRV_P;
                  pulseP <= 1'b1;
                end
              end
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end

          DEAD_N: begin
            if (phase_cnt == DEAD_LAST) begin
              phase_cnt  <= '0;
              period_cnt <= period_cnt + 6'd1;
              if (last_period) begin
                state <= RING;
              end else begin
                state  <= DRV_P;
                pulseP <= 1'b1;
              end
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end

          RING: begin
            if (phase_cnt == RING_LAST) begin
              phase_cnt <= '0;
              state     <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end

          default: begin
            state  <= IDLE;
            pulseP <= 1'b0;
            pulseN <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign blank = busy;

endmodule
